// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the two-host bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, RELEASE)
//   OWNER_*     : encoding of the debug 'owner' output
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_H0   = 2'b01;
    localparam logic [1:0] OWNER_H1   = 2'b10;

endpackage

// File: rtl/bus_arbiter_2_watchdog.sv
// bus_watchdog: transaction watchdog for the bus arbiter.
// Counts cycles from a transaction start and flags expiry when LIMIT
// cycles pass without completion.
//   clk, rst_n : clock, async active-low reset
//   start_i    : transaction granted; arms the counter from 0
//   clear_i    : disarm and clear (used once the arbiter has acted on expiry)
//   done_i     : normal completion this cycle; disarms and masks expiry
//   expired_o  : counter reached LIMIT with no completion this cycle
module bus_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic clear_i,
    input  logic done_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_C = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;
    logic         run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (clear_i || done_i) begin
            cnt_d = '0;
            run_d = 1'b0;
        end else if (start_i) begin
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q && (cnt_q != LIMIT_C)) begin
            // saturate at LIMIT so expiry holds until acted on
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // a coincident completion always beats expiry
    assign expired_o = run_q && (cnt_q == LIMIT_C) && !done_i;

endmodule

// File: rtl/bus_arbiter_2.sv
// bus_arbiter_2: two-host, one-target round-robin bus arbiter.
// Ownership is held from request until the target's ready pulse; address,
// write data/mask and read data pass through so downstream sees one host.
//
// Optional feature macro: BUS_ARBITER_TIMEOUT_EN
//   When defined, a watchdog forces completion after TIMEOUT_CYCLES in BUSY
//   and the sticky timeout_err output exists.
//
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   hN_addr/wdata/wmask        : host request payload
//   hN_wen/hN_ren              : host request level, held until hN_ready
//   hN_rdata/hN_ready          : host response (ready is a 1-cycle pulse)
//   t_addr/wdata/wmask/wen/ren : target-side request
//   t_rdata/t_ready            : target response
//   owner                      : debug, 00 none / 01 host0 / 10 host1
//   timeout_err                : sticky watchdog flag (feature only)
module bus_arbiter_2
    import bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] h0_addr,
    input  logic [31:0] h0_wdata,
    input  logic [3:0]  h0_wmask,
    input  logic        h0_wen,
    input  logic        h0_ren,
    output logic [31:0] h0_rdata,
    output logic        h0_ready,
    input  logic [31:0] h1_addr,
    input  logic [31:0] h1_wdata,
    input  logic [3:0]  h1_wmask,
    input  logic        h1_wen,
    input  logic        h1_ren,
    output logic [31:0] h1_rdata,
    output logic        h1_ready,
    output logic [31:0] t_addr,
    output logic [31:0] t_wdata,
    output logic [3:0]  t_wmask,
    output logic        t_wen,
    output logic        t_ren,
    input  logic [31:0] t_rdata,
    input  logic        t_ready,
    output logic [1:0]  owner
`ifdef BUS_ARBITER_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("bus_arbiter_2: TIMEOUT_CYCLES must be nonzero");
    end

    arb_state_t  state_q;
    logic [1:0]  owner_q;
    logic        last_h1_q;   // 1: host1 was granted last

    logic busy, own_h0, own_h1;
    logic req0, req1, grant, grant_h1;
    logic expired, fin;
    logic [31:0] ret_rdata;

    assign busy   = (state_q == BUSY);
    assign own_h0 = busy && (owner_q == OWNER_H0);
    assign own_h1 = busy && (owner_q == OWNER_H1);

    assign req0  = h0_wen || h0_ren;
    assign req1  = h1_wen || h1_ren;
    assign grant = (state_q == IDLE) && (req0 || req1);
    // on a tie the host not granted last time wins
    assign grant_h1 = req1 && (!req0 || !last_h1_q);

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic timeout_err_q;

    bus_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (grant),
        .clear_i  (expired),
        .done_i   (busy && t_ready),
        .expired_o(expired)
    );

    assign timeout_err = timeout_err_q;
`else
    assign expired = 1'b0;
`endif

    // transaction ends on target ready, or on a forced watchdog completion
    assign fin       = t_ready || expired;
    assign ret_rdata = expired ? TIMEOUT_RDATA : t_rdata;

    always_comb begin
        t_addr   = '0;
        t_wdata  = '0;
        t_wmask  = '0;
        t_wen    = 1'b0;
        t_ren    = 1'b0;
        h0_rdata = '0;
        h0_ready = 1'b0;
        h1_rdata = '0;
        h1_ready = 1'b0;
        if (own_h0) begin
            t_addr   = h0_addr;
            t_wdata  = h0_wdata;
            t_wmask  = h0_wmask;
            t_wen    = h0_wen && !expired;
            t_ren    = h0_ren && !expired;
            h0_rdata = ret_rdata;
            h0_ready = fin;
        end else if (own_h1) begin
            t_addr   = h1_addr;
            t_wdata  = h1_wdata;
            t_wmask  = h1_wmask;
            t_wen    = h1_wen && !expired;
            t_ren    = h1_ren && !expired;
            h1_rdata = ret_rdata;
            h1_ready = fin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_NONE;
            last_h1_q <= 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q   <= BUSY;
                        owner_q   <= grant_h1 ? OWNER_H1 : OWNER_H0;
                        last_h1_q <= grant_h1;
                    end
                end
                BUSY: begin
                    // a host dropping its request early does not end BUSY
                    if (fin) begin
                        state_q <= RELEASE;
                        owner_q <= OWNER_NONE;
                    end
`ifdef BUS_ARBITER_TIMEOUT_EN
                    if (expired) timeout_err_q <= 1'b1;
`endif
                end
                RELEASE: begin
                    // absorbs the cycle in which the finished host drops its request
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    owner_q <= OWNER_NONE;
                end
            endcase
        end
    end

    assign owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter_2.sv
`timescale 1ns/1ps
module tb_bus_arbiter_2;
    import bus_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] h0_addr = '0, h0_wdata = '0, h1_addr = '0, h1_wdata = '0;
    logic [3:0]  h0_wmask = '0, h1_wmask = '0;
    logic        h0_wen = 1'b0, h0_ren = 1'b0, h1_wen = 1'b0, h1_ren = 1'b0;
    logic [31:0] h0_rdata, h1_rdata;
    logic        h0_ready, h1_ready;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_wmask;
    logic        t_wen, t_ren;
    logic [31:0] t_rdata = '0;
    logic        t_ready = 1'b0;
    logic [1:0]  owner;
`ifdef BUS_ARBITER_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 clk = ~clk;

    bus_arbiter_2 #(
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .h0_addr(h0_addr), .h0_wdata(h0_wdata), .h0_wmask(h0_wmask),
        .h0_wen(h0_wen), .h0_ren(h0_ren), .h0_rdata(h0_rdata), .h0_ready(h0_ready),
        .h1_addr(h1_addr), .h1_wdata(h1_wdata), .h1_wmask(h1_wmask),
        .h1_wen(h1_wen), .h1_ren(h1_ren), .h1_rdata(h1_rdata), .h1_ready(h1_ready),
        .t_addr(t_addr), .t_wdata(t_wdata), .t_wmask(t_wmask),
        .t_wen(t_wen), .t_ren(t_ren), .t_rdata(t_rdata), .t_ready(t_ready),
        .owner(owner)
`ifdef BUS_ARBITER_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    typedef struct packed {
        logic [1:0]  own;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        wen;
        logic        ren;
    } req_t;

    typedef struct packed {
        logic        chk;
        logic [31:0] rd;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp0[$];
    rsp_t exp1[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int h0_rdy_cyc = 0, h1_rdy_cyc = 0, h1w_cyc = -1, tren_rise_cyc = 0;
    logic tren_prev = 1'b0;

    // target model controls
    int          tgt_lat = 0;      // <0: never respond
    logic [31:0] tgt_rdata = '0;
    logic        tgt_manual = 1'b0;
    logic        man_rdy = 1'b0;
    int          tcnt = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic req_t mk_req(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] wm, input logic wr);
        req_t r;
        r.own = o; r.addr = a; r.wdata = wd; r.wmask = wm; r.wen = wr; r.ren = !wr;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // host request: level held until that host's ready, dropped 2ns after the next edge
    task automatic host_txn(input int h, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] wm,
                            input logic [31:0] erd, input logic echk);
        rsp_t r;
        int n;
        logic got;
        r.chk = echk;
        r.rd  = erd;
        if (h == 0) begin
            exp0.push_back(r);
            h0_addr = a; h0_wdata = wd; h0_wmask = wm; h0_wen = wr; h0_ren = !wr;
        end else begin
            exp1.push_back(r);
            h1_addr = a; h1_wdata = wd; h1_wmask = wm; h1_wen = wr; h1_ren = !wr;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = (h == 0) ? h0_ready : h1_ready;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL host%0d_ready_wait actual=no_ready required=ready_within_200", h);
        end
        step();
        if (h == 0) begin h0_wen = 1'b0; h0_ren = 1'b0; end
        else begin h1_wen = 1'b0; h1_ren = 1'b0; end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // target model: responds tgt_lat cycles after the request appears
    initial forever begin
        @(posedge clk);
        #1;
        if (tgt_manual) begin
            t_ready = man_rdy;
        end else if (t_wen || t_ren) begin
            tcnt++;
            if (tgt_lat >= 0 && tcnt == tgt_lat + 1) begin
                t_ready = 1'b1;
                t_rdata = tgt_rdata;
                tcnt = 0;
            end else begin
                t_ready = 1'b0;
            end
        end else begin
            t_ready = 1'b0;
            tcnt = 0;
        end
        if (!t_ready) t_rdata = 32'h0BAD_0BAD;
    end

    // monitor / scoreboard
    initial begin
        rsp_t e;
        req_t q;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (h0_ready) begin
                    h0_rdy_cyc = cyc;
                    if (exp0.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL h0_unexpected_ready actual=1 required=0");
                    end else begin
                        e = exp0.pop_front();
                        if (e.chk) chk("h0_rdata", 80'(h0_rdata), 80'(e.rd));
                    end
                end
                if (h1_ready) begin
                    h1_rdy_cyc = cyc;
                    if (exp1.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL h1_unexpected_ready actual=1 required=0");
                    end else begin
                        e = exp1.pop_front();
                        if (e.chk) chk("h1_rdata", 80'(h1_rdata), 80'(e.rd));
                    end
                end
                if (t_ready && (t_wen || t_ren)) begin
                    if (exp_req.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL t_unexpected_req actual=%0h required=none", t_addr);
                    end else begin
                        q = exp_req.pop_front();
                        chk("t_req", 80'({owner, t_addr, t_wdata, t_wmask, t_wen, t_ren}), 80'(q));
                    end
                end
                if (t_wen && owner == OWNER_H1 && h1w_cyc < 0) h1w_cyc = cyc;
                if (t_ren && !tren_prev) tren_rise_cyc = cyc;
                tren_prev = t_ren;
            end else begin
                tren_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // reset state
        step();
        @(negedge clk);
        chk("rst_owner", 80'(owner), 80'(OWNER_NONE));
        chk("rst_t_req", 80'({t_wen, t_ren, t_addr, t_wdata, t_wmask}), 80'(0));
        chk("rst_ready", 80'({h0_ready, h1_ready}), 80'(0));
`ifdef BUS_ARBITER_TIMEOUT_EN
        chk("rst_timeout_err", 80'(timeout_err), 80'(0));
`endif
        step();
        rst_n = 1'b1;
        step();

        // single read, target ready 2 cycles after t_ren
        tgt_lat = 2; tgt_rdata = 32'h1234_5678;
        exp_req.push_back(mk_req(OWNER_H0, 32'h10, 32'h0, 4'h0, 1'b0));
        fork
            host_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 1'b1);
            begin
                @(negedge clk);
                chk("rd_owner_pregrant", 80'(owner), 80'(OWNER_NONE));
                @(negedge clk);
                chk("rd_owner_busy", 80'(owner), 80'(OWNER_H0));
                chk("rd_t_ren_addr", 80'({t_ren, t_addr}), 80'({1'b1, 32'h10}));
            end
        join
        @(negedge clk);
        chk("rd_owner_release", 80'(owner), 80'(OWNER_NONE));

        // tie after reset: h0, h1, h0, h1
        do_reset();
        tgt_lat = 1; tgt_rdata = 32'hA5A5_0001;
        exp_req.push_back(mk_req(OWNER_H0, 32'h100, 32'h0, 4'h0, 1'b0));
        exp_req.push_back(mk_req(OWNER_H1, 32'h200, 32'h1111_0000, 4'hF, 1'b1));
        exp_req.push_back(mk_req(OWNER_H0, 32'h104, 32'h0, 4'h0, 1'b0));
        exp_req.push_back(mk_req(OWNER_H1, 32'h204, 32'h2222_0000, 4'hC, 1'b1));
        fork
            begin
                host_txn(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hA5A5_0001, 1'b1);
                host_txn(0, 1'b0, 32'h104, 32'h0, 4'h0, 32'hA5A5_0001, 1'b1);
            end
            begin
                host_txn(1, 1'b1, 32'h200, 32'h1111_0000, 4'hF, 32'h0, 1'b0);
                host_txn(1, 1'b1, 32'h204, 32'h2222_0000, 4'hC, 32'h0, 1'b0);
            end
        join
        step();

        // late requester: h1 write arrives while h0 is BUSY
        tgt_lat = 3; tgt_rdata = 32'h0000_BEEF;
        h1w_cyc = -1;
        exp_req.push_back(mk_req(OWNER_H0, 32'h40, 32'h0, 4'h0, 1'b0));
        exp_req.push_back(mk_req(OWNER_H1, 32'h80, 32'hCAFE_F00D, 4'b0011, 1'b1));
        fork
            host_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0000_BEEF, 1'b1);
            begin
                step();
                step();
                host_txn(1, 1'b1, 32'h80, 32'hCAFE_F00D, 4'b0011, 32'h0, 1'b0);
            end
        join
        chk("late_wen_gap", 80'(h1w_cyc - h0_rdy_cyc), 80'(3));
        step();

        // reset mid-BUSY (h0 owns, so last-grant becomes h0 before the reset)
        tgt_lat = -1;
        h0_addr = 32'h300; h0_wdata = 32'h0; h0_wmask = 4'h0; h0_ren = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("prereset_t_ren", 80'({t_ren, owner}), 80'({1'b1, OWNER_H0}));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_t_ren_owner", 80'({t_ren, t_wen, owner}), 80'(0));
        h0_ren = 1'b0;
        step();
        rst_n = 1'b1;

        // stray / spurious t_ready in IDLE
        tgt_manual = 1'b1; man_rdy = 1'b1;
        step();
        man_rdy = 1'b0;
        @(negedge clk);
        chk("stray_ready", 80'({h0_ready, h1_ready, owner}), 80'(0));
        step();
        tgt_manual = 1'b0;

        // still IDLE with last-grant back at host1: tie goes to h0, 1-cycle grant, 3-cycle turn
        tgt_lat = 0; tgt_rdata = 32'h0F0F_0F0F;
        exp_req.push_back(mk_req(OWNER_H0, 32'h500, 32'h0, 4'h0, 1'b0));
        exp_req.push_back(mk_req(OWNER_H1, 32'h600, 32'h0, 4'h0, 1'b0));
        fork
            host_txn(0, 1'b0, 32'h500, 32'h0, 4'h0, 32'h0F0F_0F0F, 1'b1);
            host_txn(1, 1'b0, 32'h600, 32'h0, 4'h0, 32'h0F0F_0F0F, 1'b1);
            begin
                @(negedge clk);
                chk("post_owner_pregrant", 80'(owner), 80'(OWNER_NONE));
                @(negedge clk);
                chk("post_owner_busy", 80'({owner, t_ren}), 80'({OWNER_H0, 1'b1}));
            end
        join
        chk("b2b_cycles", 80'(h1_rdy_cyc - h0_rdy_cyc), 80'(3));
        step();

`ifdef BUS_ARBITER_TIMEOUT_EN
        // target never answers: forced ready after 8 cycles with TIMEOUT_RDATA
        chk("pre_timeout_err", 80'(timeout_err), 80'(0));
        tgt_lat = -1;
        host_txn(0, 1'b0, 32'h700, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);
        chk("timeout_latency", 80'(h0_rdy_cyc - tren_rise_cyc), 80'(8));
        chk("timeout_err_set", 80'(timeout_err), 80'(1));
        tgt_lat = 0; tgt_rdata = 32'h1;
        exp_req.push_back(mk_req(OWNER_H1, 32'h704, 32'h55, 4'h1, 1'b1));
        host_txn(1, 1'b1, 32'h704, 32'h55, 4'h1, 32'h0, 1'b0);
        chk("timeout_err_sticky", 80'(timeout_err), 80'(1));
        step();
`endif

        chk("queues_drained", 80'(exp0.size() + exp1.size() + exp_req.size()), 80'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2.md
# bus_arbiter_2

Two-host, one-target bus arbiter that shares the SoC system bus (the bus feeding the address-decoding bus hub) between the CPU core and a second master, such as a DMA or debug loader. It uses round-robin fairness and holds ownership for the whole transaction, from ren/wen until ready. It passes address, write data, write mask and read data through unchanged, so the downstream hub and its devices see a single host.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles, counted from downstream request start. Used only with the timeout feature.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out read.

Ports:
- clk  in  1: single bus clock.
- rst_n  in  1: reset, asynchronous and active-low.
- h0_addr / h1_addr  in  32: host byte address.
- h0_wdata / h1_wdata  in  32: host write data.
- h0_wmask / h1_wmask  in  4: host byte write mask.
- h0_wen, h0_ren / h1_wen, h1_ren  in  1 each: host request, level, held until that host's ready.
- h0_rdata / h1_rdata  out  32: read data, valid while that host's ready is high.
- h0_ready / h1_ready  out  1: one-cycle completion pulse.
- t_addr, t_wdata, t_wmask  out  32/32/4: target-side request.
- t_wen, t_ren  out  1: target request.
- t_rdata  in  32: target read data.
- t_ready  in  1: target completion pulse.
- owner  out  2: debug; 2'b00 none, 2'b01 host0, 2'b10 host1.
- timeout_err  out  1: sticky flag; exists only with the timeout feature.

## Operation
- State machine with three states: IDLE → BUSY → RELEASE → IDLE.
- IDLE: a host requests when wen|ren is high.
  - One requester: that host is granted.
  - Both requesting: the host not granted last time wins.
  - The last-grant register resets to host1, so host0 wins the first tie.
  - On grant: owner is registered, last-grant is updated, go to BUSY.
- BUSY:
  - t_addr, t_wdata and t_wmask mirror the owner's inputs combinationally.
  - t_wen and t_ren mirror the owner's wen and ren.
  - The owner's rdata equals t_rdata, and the owner's ready equals t_ready.
  - The non-owner sees ready=0 and rdata=0.
  - When t_ready is high: go to RELEASE.
  - If the owner drops its request before t_ready (protocol violation): t_wen and t_ren drop, and the arbiter stays in BUSY until t_ready arrives.
- RELEASE: lasts one cycle. All t_* requests are 0 and no grant is made. This absorbs the cycle in which the finished host deasserts its request. Next state is IDLE.
- Outside BUSY:
  - t_wen, t_ren, h*_ready = 0.
  - t_addr, t_wdata = 0 and t_wmask = 0.
  - owner = 00.
- If wen and ren are both high together, they are passed through as-is. The arbiter does not validate them.

## Timing
- Request first seen high in IDLE at cycle N: grant at the edge ending N, and t_ren/t_wen high from cycle N+1.
- Arbitration overhead: 1 cycle before the transaction and 1 cycle (RELEASE) after it.
- Back-to-back cost: with the target ready in the same cycle it is requested, one transaction occupies 3 cycles (BUSY, RELEASE, IDLE-grant).
- Ready to host: combinational in the same cycle as t_ready. There is no added latency on the return path.
- Reset, asserted at any time including mid-transaction:
  - State returns to IDLE, owner = 00, last-grant = host1.
  - The watchdog counter clears to 0 and timeout_err clears to 0.
  - All outputs are 0 asynchronously.
  - An in-flight target transaction is abandoned. Any t_ready that arrives later in IDLE is ignored.
- t_ready arriving in IDLE or RELEASE is ignored and forwarded to no host.

## Configuration
- BUS_ARBITER_TIMEOUT_EN, when defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in BUSY.
  - If it reaches TIMEOUT_CYCLES without t_ready, the arbiter forces a one-cycle owner ready. Read data is TIMEOUT_RDATA for a read and is don't-care for a write.
  - t_wen and t_ren drop, timeout_err is set and stays set until reset, and the arbiter goes to RELEASE.
  - If t_ready coincides with expiry, t_ready wins and timeout_err stays unset.
- BUS_ARBITER_TIMEOUT_EN, when undefined: no counter and no timeout_err port. BUSY waits indefinitely.

## Structure
- Shared package bus_arb_pkg:
  - arb_state_t enum: IDLE, BUSY, RELEASE.
  - owner encoding constants OWNER_NONE, OWNER_H0, OWNER_H1.
- One sub-module, bus_watchdog. It takes start, clear and done inputs and produces an expired output. It is instantiated only under BUS_ARBITER_TIMEOUT_EN.
- The top module holds the FSM, the round-robin pointer and the datapath muxes.

## Test plan
- Single read: h0_ren with addr 0x0000_0010; target returns 0x1234_5678 with ready 2 cycles after t_ren. Required: h0_rdata = 0x1234_5678 with h0_ready for 1 cycle; h1_ready stays 0; owner goes 01 → 00.
- Tie after reset: h0 and h1 request together, then keep requesting. Required: grant order h0, h1, h0, h1 across 4 transactions; t_addr matches the granted host each time.
- Late requester: h1 write of 0xCAFE_F00D with mask 4'b0011 arrives while h0 is BUSY. Required: h1's t_wen is not seen until after h0's ready plus RELEASE; t_wdata and t_wmask exact.
- Reset mid-BUSY: pull rst_n low while t_ren is high. Required: t_ren = 0 and owner = 00 in the same cycle; a stray t_ready after reset produces no host ready.
- Timeout, with BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8: the target never responds to a read. Required: the owner's ready arrives 8 cycles after t_ren rises, with rdata 0xDEAD_BEEF; timeout_err = 1 and stays 1.
- Spurious t_ready while IDLE. Required: no h*_ready, state stays IDLE.
